// File: rtl/fios_mm_scheduler.sv
// Round-robin scheduler sharing one FIOS_CASC Montgomery multiplier among
// REQ_NB requesters. Turns the multiplier's fetch/push strobes into word
// indices and memory enables for the granted requester, and flags
// protocol violations in a sticky error bit.
module fios_mm_scheduler #(
  parameter int REQ_NB = 4,
  parameter int s      = 8,
  parameter int IDX_W  = $clog2(s),
  parameter int ID_W   = $clog2(REQ_NB)
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [REQ_NB-1:0] req_i,
  output logic [REQ_NB-1:0] gnt_o,
  output logic [REQ_NB-1:0] done_o,
  output logic              err_o,
  input  logic              err_clr_i,
  output logic [ID_W-1:0]   sel_id_o,
  output logic              mm_start_o,
  input  logic              b_fetch_i,
  input  logic              p_fetch_i,
  input  logic              RES_push_i,
  input  logic              mm_done_i,
  output logic              b_rd_en_o,
  output logic [IDX_W-1:0]  b_idx_o,
  output logic              p_rd_en_o,
  output logic [IDX_W-1:0]  p_idx_o,
  output logic              res_we_o,
  output logic [IDX_W-1:0]  res_idx_o,
  output logic              busy_o
);

  // r_cnt must be able to reach s itself so a full result is detectable
  localparam int R_W = $clog2(s + 1);
  localparam logic [R_W-1:0]   R_FULL = R_W'(s);
  localparam logic [IDX_W-1:0] W_LAST = IDX_W'(s - 1);
  localparam logic [ID_W-1:0]  ID_LAST = ID_W'(REQ_NB - 1);

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [REQ_NB-1:0]   gnt_q;
  logic [ID_W-1:0]     sel_q, rr_q, pick_id, cand;
  logic                pick_vld;
  logic                busy_q, err_q, err_evt, res_full;
  logic [IDX_W-1:0]    b_cnt, p_cnt;
  logic [R_W-1:0]      r_cnt;
  int                  tmp;

  assign gnt_o     = gnt_q;
  assign sel_id_o  = sel_q;
  assign busy_o    = busy_q;
  assign err_o     = err_q;
  assign b_idx_o   = b_cnt;
  assign p_idx_o   = p_cnt;
  assign res_idx_o = r_cnt[IDX_W-1:0];
  assign res_full  = (r_cnt == R_FULL);

  // Round-robin pick: scan offsets high to low so the nearest requester
  // at or above rr_q (with wrap) is the last, winning assignment.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    cand     = '0;
    tmp      = 0;
    for (int i = REQ_NB - 1; i >= 0; i--) begin
      tmp = int'(rr_q) + i;
      if (tmp >= REQ_NB) tmp = tmp - REQ_NB;
      cand = ID_W'(tmp);
      if (req_i[cand]) begin
        pick_vld = 1'b1;
        pick_id  = cand;
      end
    end
  end

  // State register
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state, strobe-to-enable decode and error detection
  always_comb begin
    state_d    = state_q;
    mm_start_o = 1'b0;
    b_rd_en_o  = 1'b0;
    p_rd_en_o  = 1'b0;
    res_we_o   = 1'b0;
    done_o     = '0;
    err_evt    = 1'b0;
    unique case (state_q)
      IDLE:  if (pick_vld) state_d = START;
      START: begin
        mm_start_o = 1'b1;
        state_d    = RUN;
      end
      RUN: begin
        b_rd_en_o = b_fetch_i;
        p_rd_en_o = p_fetch_i;
        // a push past the last result word is dropped, not written
        res_we_o  = RES_push_i && !res_full;
        if (RES_push_i && res_full) err_evt = 1'b1;
        if (mm_done_i) begin
          state_d = DONE;
          if (!res_full) err_evt = 1'b1;
        end
      end
      DONE: begin
        done_o  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_q != RUN && (b_fetch_i || p_fetch_i || RES_push_i || mm_done_i))
      err_evt = 1'b1;
    // grantee must hold its request until it sees done_o
    if (busy_q && (req_i & gnt_q) == '0)
      err_evt = 1'b1;
  end

  // Grant, select, busy and round-robin pointer
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      gnt_q  <= '0;
      sel_q  <= '0;
      busy_q <= 1'b0;
      rr_q   <= '0;
    end else begin
      if (state_q == IDLE && pick_vld) begin
        gnt_q          <= '0;
        gnt_q[pick_id] <= 1'b1;
        sel_q          <= pick_id;
        busy_q         <= 1'b1;
      end else if (state_q == DONE) begin
        gnt_q  <= '0;
        busy_q <= 1'b0;
        rr_q   <= (sel_q == ID_LAST) ? '0 : sel_q + 1'b1;
      end
    end
  end

  // Word counters: b/p wrap each outer iteration, r saturates at s
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      b_cnt <= '0;
      p_cnt <= '0;
      r_cnt <= '0;
    end else if (state_q == START) begin
      b_cnt <= '0;
      p_cnt <= '0;
      r_cnt <= '0;
    end else if (state_q == RUN) begin
      if (b_fetch_i) b_cnt <= (b_cnt == W_LAST) ? '0 : b_cnt + 1'b1;
      if (p_fetch_i) p_cnt <= (p_cnt == W_LAST) ? '0 : p_cnt + 1'b1;
      if (res_we_o)  r_cnt <= r_cnt + 1'b1;
    end
  end

  // Sticky error; a new error wins over a simultaneous clear
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i)       err_q <= 1'b0;
    else if (err_evt)   err_q <= 1'b1;
    else if (err_clr_i) err_q <= 1'b0;
  end

endmodule

// File: doc/fios_mm_scheduler.md
Name: fios_mm_scheduler

Overview:
- Shares one FIOS_CASC Montgomery multiplier among REQ_NB requesters, e.g. exponentiation engines or ECC point units.
- Arbitrates with a round-robin policy and issues a one-cycle start to the multiplier.
- Converts the multiplier's b_fetch/p_fetch/RES_push strobes into word indices and read/write enables on the operand and result memories of the granted requester.
- Reports per-requester completion and protocol errors.

Parameters:
REQ_NB, 4, number of requesters (2..16)
s, 8, number of 17-bit words per operand
IDX_W, $clog2(s), width of word index outputs
ID_W, $clog2(REQ_NB), width of requester id

Ports:
clock_i  in  1  clock
reset_i  in  1  asynchronous reset, active-low
req_i  in  REQ_NB  per-requester request level, held until its done_o pulse
gnt_o  out  REQ_NB  one-hot grant, held for whole job
done_o  out  REQ_NB  one-cycle completion pulse to the granted requester
err_o  out  1  sticky protocol error flag
err_clr_i  in  1  clears err_o
sel_id_o  out  ID_W  binary id of current grantee (operand/result mux select)
mm_start_o  out  1  start pulse to multiplier
b_fetch_i  in  1  multiplier b word strobe
p_fetch_i  in  1  multiplier p word strobe
RES_push_i  in  1  multiplier result word strobe
mm_done_i  in  1  multiplier done pulse
b_rd_en_o  out  1  operand b memory read enable
b_idx_o  out  IDX_W  operand b word index
p_rd_en_o  out  1  modulus p memory read enable
p_idx_o  out  IDX_W  modulus p word index
res_we_o  out  1  result memory write enable
res_idx_o  out  IDX_W  result word index
busy_o  out  1  high from grant until done_o

Behaviour:
- Reset (reset_i low, async): state IDLE. All outputs are 0, all indices 0, and the rr pointer is 0. A reset mid-job aborts the job silently and issues no done_o.
- IDLE:
  - If any req_i is high, the grantee is the first requester found by searching from rr pointer upward with wrap-around.
  - gnt_o and sel_id_o are registered, busy_o goes to 1, and the state moves to START on the next edge.
  - If no req_i is high, the state stays in IDLE.
- START: mm_start_o=1 for exactly one cycle; counters b_cnt, p_cnt and r_cnt are cleared; then RUN.
- RUN:
  - b_fetch_i drives b_rd_en_o=1 in the same cycle (combinational) with b_idx_o=b_cnt, then b_cnt increments modulo s.
  - p_fetch_i is handled identically with p_rd_en_o, p_idx_o and p_cnt.
  - RES_push_i drives res_we_o=1 with res_idx_o=r_cnt, then r_cnt increments.
  - Simultaneous b/p/RES strobes are all served in the same cycle.
  - b_cnt and p_cnt wrap at s, because the multiplier re-fetches b and p once per outer iteration. r_cnt does not wrap.
  - On mm_done_i, the state moves to DONE.
- DONE:
  - done_o[grantee]=1 for one cycle; gnt_o and busy_o clear on the following edge.
  - rr pointer becomes grantee+1, modulo REQ_NB; then IDLE.
  - Minimum gap between jobs is 1 idle cycle.
- Errors (set err_o; sticky until err_clr_i; err_clr_i and a new error in the same cycle leave err_o set):
  - mm_done_i arrives with r_cnt≠s.
  - RES_push_i arrives with r_cnt==s; the write is suppressed.
  - Any fetch/push/done strobe arrives outside RUN.
  - The granted requester drops req_i before done_o.
  - The job still completes normally after an error.
- Strobes while not granted never assert any enable output.
- A requester dropping req_i while not granted is simply skipped.
- Fairness: a continuously requesting set is served in strict cyclic order; no requester waits more than REQ_NB-1 jobs.

Test Plan:
- Single job, s=8, req_i=0001: gnt_o=0001 one cycle after request, mm_start_o pulses 1 cycle later. 16 b_fetch_i give b_idx_o 0..7,0..7. 8 RES_push_i give res_idx_o 0..7. mm_done_i gives done_o=0001 next cycle; err_o stays 0.
- All four requesting continuously, rr=0: grants in order 0001,0010,0100,1000,0001; each done_o matches its grant.
- Simultaneous b_fetch_i, p_fetch_i and RES_push_i in one cycle: b_rd_en_o, p_rd_en_o and res_we_o are all high, each with its own index, and each counter advances by one.
- mm_done_i after only 7 pushes: err_o=1 and done_o still pulses. A 9th push attempt: res_we_o=0 and err_o=1. err_clr_i clears err_o.
- Reset asserted during RUN at r_cnt=3: outputs go to 0 asynchronously, with no done_o. After release, the next job starts at rr=0 with res_idx_o from 0.
- req_i=0100 dropped mid-job: err_o=1 and the job runs to mm_done_i. req_i=0010 pulsed and dropped while another job is active: it is never granted.
